core_sequencer: RTL

//  Multi-cycle sequencer for the RV32I core. Owns PC and IR and steps each instruction

---
 rtl/core_pkg.sv | 35 +++
 rtl/bus_watchdog.sv | 41 ++++
 rtl/core_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encoding,
// decoder writeback/branch codes, fault cause codes and the reset NOP.
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // Decoder writeback source
  localparam logic [1:0] RW_NONE = 2'd0;
  localparam logic [1:0] RW_ALU  = 2'd1;
  localparam logic [1:0] RW_MEM  = 2'd2;
  localparam logic [1:0] RW_PC4  = 2'd3;

  // Decoder branch kind (consumed by the pc_next path outside this block)
  localparam logic [1:0] BRA_NONE = 2'd0;
  localparam logic [1:0] BRA_COND = 2'd1;
  localparam logic [1:0] BRA_JAL  = 2'd2;
  localparam logic [1:0] BRA_JALR = 2'd3;

  // Latched fault cause
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
  localparam logic [1:0] FAULT_BUS      = 2'd2;
  localparam logic [1:0] FAULT_MISALIGN = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/bus_watchdog.sv
// Bus wait-state watchdog shared by the fetch and data phases.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear_i      hold the wait counter at zero (no request outstanding)
//   waiting_i    a request is being held this cycle
//   ack_i        the held request completes this cycle
//   expired_o    the request has waited BUS_TIMEOUT-1 cycles and is not acked now
module bus_watchdog #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic waiting_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(BUS_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (waiting_i && !ack_i && cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // An ack in the expiry cycle wins over the timeout.
  assign expired_o = waiting_i && !ack_i && (cnt_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: owns PC and IR, steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives the bus handshakes and the regfile
// write strobe, and latches EBREAK halt or fault conditions.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req/addr/ack/rdata    instruction bus (req held until ack)
//   ir, pc                     latched instruction and its address
//   pc_next                    next PC from the branch/ALU path
//   dec_*                      decoder controls for the instruction in ir
//   dmem_req/we/ack            data bus (req held until ack)
//   rf_we                      regfile write strobe
//   state                      current state (debug)
//   halted, fault, fault_cause latched terminal status
//   cycle_cnt, instret_cnt     active-cycle and retired-instruction counters
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [1:0]  dec_r_w_src,
  input  logic        dec_mem_en,
  input  logic        dec_mem_wr,
  input  logic        dec_brk,
  input  logic        dec_illegal,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        bus_expired;

  // Only one bus phase is ever active, so a single watchdog serves both.
  bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!(imem_req || dmem_req)),
    .waiting_i (imem_req || dmem_req),
    .ack_i     (imem_req ? imem_ack : dmem_ack),
    .expired_o (bus_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    cause_d   = cause_q;
    cycle_d   = cycle_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (bus_expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = FAULT_BUS;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = FAULT_ILLEGAL;
        end else if (dec_brk) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          instret_d = instret_q + 32'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = dec_mem_en ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (bus_expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = FAULT_BUS;
        end
      end
      S_WB: begin
        if (pc_next[1:0] != 2'b00) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = FAULT_MISALIGN;
        end else begin
          pc_d      = pc_next;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: ;  // HALT and FAULT are absorbing
    endcase

    if (state_q != S_HALT && state_q != S_FAULT) cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP;
      cycle_q   <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) && dec_mem_wr;
  // Stores never write the regfile, whatever source the decoder reports.
  assign rf_we       = (state_q == S_WB) && (dec_r_w_src != RW_NONE) &&
                       !(dec_mem_en && dec_mem_wr);
  assign ir          = ir_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
